// File: rtl/rr_grant_capture_if.sv
// Bus bundle between the round-robin arbiter side, the capture FIFO and the
// next stage.
//
// Handshake: the head of the FIFO is offered with out_valid; it is consumed on
// a rising clock edge where out_valid && out_ready are both high. While
// out_valid is high and out_ready is low, out_valid/out_data/out_id hold
// stable. out_ready has no effect while out_valid is low.
interface rr_grant_capture_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [3:0]          grant;
    logic [4*DATA_W-1:0] req_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_id;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic [DROP_W-1:0]   drop_cnt;
    logic                err_multi;

    // Driving side: arbiter grant/payloads and the downstream ready.
    modport master (
        output grant, req_data, out_ready,
        input  out_valid, out_data, out_id, count, full, drop_cnt, err_multi
    );

    // Capture block side.
    modport slave (
        input  grant, req_data, out_ready,
        output out_valid, out_data, out_id, count, full, drop_cnt, err_multi
    );
endinterface

// File: rtl/rr_grant_capture.sv
// Captures the payload of the one-hot-granted requester, tagged with its
// index, into a show-ahead FIFO. Full-FIFO pushes without a same-cycle pop are
// counted as drops; multi-hot grants are ignored and raise a sticky error.
module rr_grant_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_grant_capture_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [1:0]        id_q   [DEPTH];
    logic [1:0]        id_d   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              err_multi_q, err_multi_d;

    logic              one_hot;
    logic              multi_hot;
    logic [1:0]        grant_id;
    logic              push;
    logic              pop;
    logic              drop;

    // Classify the grant and work out push/pop/drop for this cycle.
    always_comb begin
        one_hot   = (bus.grant != 4'b0) && ((bus.grant & (bus.grant - 4'd1)) == 4'b0);
        multi_hot = (bus.grant != 4'b0) && !one_hot;
        grant_id  = 2'd0;
        case (bus.grant)
            4'b0010: grant_id = 2'd1;
            4'b0100: grant_id = 2'd2;
            4'b1000: grant_id = 2'd3;
            default: grant_id = 2'd0;
        endcase
        pop  = (count_q != '0) && bus.out_ready;
        push = one_hot && ((count_q != CNT_FULL) || pop);
        drop = one_hot && (count_q == CNT_FULL) && !pop;
    end

    // Next-state for storage, pointers, occupancy and status counters.
    always_comb begin
        data_d      = data_q;
        id_d        = id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_cnt_d  = drop_cnt_q;
        err_multi_d = err_multi_q | multi_hot;
        if (push) begin
            data_d[wr_ptr_q] = bus.req_data[grant_id*DATA_W +: DATA_W];
            id_d[wr_ptr_q]   = grant_id;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // State registers; reset clears storage so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            err_multi_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            id_q        <= id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            err_multi_q <= err_multi_d;
        end
    end

    // Show-ahead outputs come straight from registered state only.
    always_comb begin
        bus.out_valid = (count_q != '0);
        bus.out_data  = data_q[rd_ptr_q];
        bus.out_id    = id_q[rd_ptr_q];
        bus.count     = count_q;
        bus.full      = (count_q == CNT_FULL);
        bus.drop_cnt  = drop_cnt_q;
        bus.err_multi = err_multi_q;
    end
endmodule

// File: tb/tb_rr_grant_capture.sv
// Directed bench for rr_grant_capture: capture, ordering, drops with
// saturation, full push+pop, multi-hot error and asynchronous reset.
module tb_rr_grant_capture;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rr_grant_capture_if #(.DATA_W(8), .DEPTH(4), .DROP_W(8)) bus ();

    rr_grant_capture #(.DATA_W(8), .DEPTH(4), .DROP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [1:0] id,
                              input logic [7:0] data, input logic [2:0] cnt);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            check({tag, ".id"},   32'(bus.out_id),   32'(id));
            check({tag, ".data"}, 32'(bus.out_data), 32'(data));
        end
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".full"},  32'(bus.full),  32'(cnt == 3'd4));
    endtask

    task automatic push_one(input logic [3:0] g);
        bus.grant = g;
        step();
        bus.grant = 4'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.grant     = 4'b0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check_head("rst", 1'b0, 2'd0, 8'h00, 3'd0);
        check("rst.data", 32'(bus.out_data), 32'h0);
        check("rst.id", 32'(bus.out_id), 32'h0);
        check("rst.drop", 32'(bus.drop_cnt), 32'h0);
        check("rst.err", 32'(bus.err_multi), 32'h0);
        rst_n = 1'b1;

        // Single capture, 1-cycle latency
        bus.req_data[2*8 +: 8] = 8'hA5;
        push_one(4'b0100);
        check_head("single", 1'b1, 2'd2, 8'hA5, 3'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_head("single_pop", 1'b0, 2'd0, 8'h00, 3'd0);

        // Rotating grants fill the FIFO
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        push_one(4'b1000);
        push_one(4'b0100);
        push_one(4'b0010);
        push_one(4'b0001);
        check_head("fill", 1'b1, 2'd3, 8'h44, 3'd4);

        // Two drops while full, contents unchanged
        push_one(4'b0001);
        push_one(4'b0010);
        check("drop2.cnt", 32'(bus.drop_cnt), 32'd2);
        check_head("drop2", 1'b1, 2'd3, 8'h44, 3'd4);

        // Full with pop: push accepted, count stays full
        bus.req_data[1*8 +: 8] = 8'h77;
        bus.out_ready = 1'b1;
        push_one(4'b0010);
        check_head("fullpp", 1'b1, 2'd2, 8'h33, 3'd4);
        check("fullpp.drop", 32'(bus.drop_cnt), 32'd2);

        // Drain in capture order
        step(); check_head("drain1", 1'b1, 2'd1, 8'h22, 3'd3);
        step(); check_head("drain2", 1'b1, 2'd0, 8'h11, 3'd2);
        step(); check_head("drain3", 1'b1, 2'd1, 8'h77, 3'd1);
        step(); check_head("drain4", 1'b0, 2'd0, 8'h00, 3'd0);
        bus.out_ready = 1'b0;

        // Simultaneous push and pop mid-occupancy
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        push_one(4'b0001);
        push_one(4'b0100);
        bus.out_ready = 1'b1;
        push_one(4'b1000);
        check_head("midpp", 1'b1, 2'd2, 8'h33, 3'd2);
        step();
        check_head("midpp2", 1'b1, 2'd3, 8'h44, 3'd1);
        step();
        bus.out_ready = 1'b0;
        check_head("midpp3", 1'b0, 2'd0, 8'h00, 3'd0);

        // Drop counter saturation
        repeat (4) push_one(4'b0001);
        repeat (253) push_one(4'b0010);
        check("sat255", 32'(bus.drop_cnt), 32'hFF);
        repeat (5) push_one(4'b0100);
        check("sat_hold", 32'(bus.drop_cnt), 32'hFF);
        check_head("sat_head", 1'b1, 2'd0, 8'h11, 3'd4);

        // Multi-hot grant: no push, sticky error
        check("err_pre", 32'(bus.err_multi), 32'h0);
        push_one(4'b0110);
        check("multi.err", 32'(bus.err_multi), 32'h1);
        check("multi.drop", 32'(bus.drop_cnt), 32'hFF);
        check_head("multi", 1'b1, 2'd0, 8'h11, 3'd4);
        bus.out_ready = 1'b1;
        push_one(4'b0100);
        push_one(4'b0100);
        check("multi.sticky", 32'(bus.err_multi), 32'h1);
        repeat (4) step();
        bus.out_ready = 1'b0;
        check_head("multi.drain", 1'b0, 2'd0, 8'h00, 3'd0);
        check("multi.sticky2", 32'(bus.err_multi), 32'h1);

        // Asynchronous reset with three entries stored
        push_one(4'b0001);
        push_one(4'b0010);
        push_one(4'b1000);
        check_head("pre_arst", 1'b1, 2'd0, 8'h11, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        check_head("arst", 1'b0, 2'd0, 8'h00, 3'd0);
        check("arst.drop", 32'(bus.drop_cnt), 32'h0);
        check("arst.err", 32'(bus.err_multi), 32'h0);
        #1 rst_n = 1'b1;
        push_one(4'b0100);
        check_head("post_arst", 1'b1, 2'd2, 8'h33, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_grant_capture.md
Name: rr_grant_capture

Overview:
- Downstream consumer of the 4-way round-robin arbiter.
- Takes the arbiter's 4-bit grant vector and the four requesters' payloads.
- Captures the granted requester's payload, tagged with its index, into a small show-ahead FIFO.
- Presents the FIFO head to the next stage on a valid/ready handshake, and flags drops and malformed (multi-hot) grants.

Parameters:
- DATA_W, 8, payload width per requester.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- grant  input  4  grant vector from the arbiter; bit i = requester i granted this cycle.
- req_data  input  4*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  DATA_W  head payload.
- out_id  output  2  head requester index.
- count  output  clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- drop_cnt  output  DROP_W  number of valid grants lost because the FIFO was full.
- err_multi  output  1  sticky; set when grant has more than one bit set.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, rd/wr pointers 0, count 0, out_valid 0, full 0, drop_cnt 0, err_multi 0. out_data/out_id are don't-care while out_valid=0; the implementation drives them to 0 after reset.
- Reset asserted mid-operation discards all stored entries immediately. The first push is possible on the first rising edge with rst_n high.
- Grant classification each cycle:
  - grant == 0: idle, no push.
  - grant one-hot: valid push request; id = index of the set bit; payload = req_data slice for that id.
  - grant with 2+ bits set: no push, drop_cnt unchanged, err_multi set to 1 on that edge and held until reset.
- Pop: occurs on a rising edge when out_valid && out_ready. out_ready while out_valid=0 has no effect.
- Push when not full: write {id, payload} at wr_ptr; wr_ptr increments modulo DEPTH.
- Push when full:
  - With a pop in the same cycle, the push is accepted; count stays DEPTH.
  - Without a pop, the entry is dropped; drop_cnt increments, saturating at all-ones.
- Simultaneous push and pop with 0 < count < DEPTH: both happen; count unchanged.
- Empty FIFO: no pop is possible (out_valid=0). A push on edge N makes out_valid=1 with that entry on out_data/out_id after edge N (1-cycle latency, no bypass).
- Show-ahead: out_data/out_id/out_valid reflect the head combinationally from storage and pointers. They hold stable while out_valid && !out_ready.
- Ordering: strict FIFO; entries leave in capture order.
- count: +1 on push-only, -1 on pop-only, unchanged otherwise. full = (count == DEPTH). out_valid = (count != 0).
- Pointer wrap: pointers use clog2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- No combinational path from grant or req_data to any output.

Test Plan:
- Reset, then grant=4'b0100, req_data slice2=8'hA5 for one cycle, out_ready=0 -> next cycle out_valid=1, out_id=2, out_data=8'hA5, count=1.
- Rotating grants 1000,0100,0010,0001 with payloads 11,22,33,44, out_ready=0 -> count=4, full=1. Then out_ready=1 -> pops ids 3,2,1,0 with data 44,33,22,11 in order, then out_valid=0.
- FIFO full, out_ready=0, two more one-hot grants -> drop_cnt=2, contents unchanged. Repeat drops past 255 -> drop_cnt holds 8'hFF.
- FIFO full, out_ready=1, one-hot grant id1 data 77 -> head pops, 77 enqueued at tail, count stays 4, drop_cnt unchanged.
- grant=4'b0110 for one cycle -> no push, count unchanged, err_multi=1. It stays 1 through further valid traffic until rst_n pulses low.
- Three entries stored, rst_n pulsed low between clock edges -> out_valid, count, full, drop_cnt, err_multi all 0 immediately. A grant on the next edge after release is captured normally.
